tap_regs: RTL
=============

TAP_REGS -- requirements
Module: tap_regs

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h1000_5A5B, is the device ID word; bit 0 SHALL be 1.
REQ-002 Parameter IR_RESET, default 5'h01, is the instruction loaded on reset (IDCODE).
REQ-003 tck_i  input  1  JTAG clock; all state changes on posedge except tdo_o.
REQ-004 trst_i  input  1  reset, asynchronous, active-high.
REQ-005 tdi_i  input  1  serial data in.
REQ-006 shiftIR_i, captureIR_i, updateIR_i  input  1 each  IR state decodes from the TAP controller.
REQ-007 shiftDR_i, captureDR_i, updateDR_i  input  1 each  DR state decodes from the TAP controller.
REQ-008 SelectIR_i  input  1  high selects the IR chain for tdo_o.
REQ-009 tdo_o  output  1  serial data out, updated on negedge tck_i.
REQ-010 instr_o  output  5  active instruction.
REQ-011 user_rdata_i  input  32  parallel value captured by USERDATA.
REQ-012 user_wdata_o  output  32  parallel value written by USERDATA.
REQ-013 user_wvalid_o  output  1  one-tck strobe marking a new user_wdata_o.

Function
REQ-014 Instructions: 5'h01 IDCODE (32-bit DR), 5'h10 USERDATA (32-bit DR), 5'h1F BYPASS (1-bit DR); every other code SHALL select BYPASS.
REQ-015 Capture IR: on posedge with captureIR_i=1, ir_sr <= 5'b00001.
REQ-016 Shift IR: on posedge with shiftIR_i=1, ir_sr <= {tdi_i, ir_sr[4:1]} (LSB out first).
REQ-017 Update IR: on posedge with updateIR_i=1, instr_o <= ir_sr; instr_o SHALL NOT change at any other time except reset.
REQ-018 Capture DR: on posedge with captureDR_i=1, the selected DR loads IDCODE_VALUE, user_rdata_i, or 1'b0 (BYPASS).
REQ-019 Shift DR: on posedge with shiftDR_i=1, the selected DR shifts right, tdi_i entering the MSB (bit 31, or bit 0 for BYPASS).
REQ-020 Non-selected DRs SHALL hold their contents during capture/shift/update.
REQ-021 Update DR with USERDATA: on posedge with updateDR_i=1, user_wdata_o <= user shift register and user_wvalid_o <= 1 for exactly one tck cycle; otherwise user_wvalid_o <= 0.
REQ-022 Update DR with IDCODE or BYPASS: no output change; user_wvalid_o SHALL stay 0.
REQ-023 On negedge tck_i: tdo_o <= ir_sr[0] if shiftIR_i & SelectIR_i; the selected DR bit 0 if shiftDR_i; else 1'b0.
REQ-024 Shift length beyond register width: bits captured from tdi_i SHALL emerge on tdo_o after the register length (32, 5, or 1 cycles); no saturation.
REQ-025 Simultaneous capture and shift inputs are illegal; capture SHALL take priority.
REQ-026 A decode change of instr_o SHALL take effect from the next capture; a shift already in progress uses the instruction latched at its capture.

Reset
REQ-027 On trst_i=1, at any time including mid-shift: instr_o=IR_RESET, ir_sr=5'b00001, IDCODE DR=IDCODE_VALUE, user DR=0, bypass=0, user_wdata_o=0, user_wvalid_o=0, tdo_o=0.
REQ-028 After trst_i deasserts, the first posedge SHALL act on the current decode inputs.

Configuration
REQ-029 Macro TAP_USERDATA_EN: when defined, USERDATA and user_* ports behave per REQ-018..022.
REQ-030 Without TAP_USERDATA_EN: 5'h10 decodes as BYPASS, user_wdata_o is tied 0, user_wvalid_o is tied 0, user_rdata_i is ignored, and the ports remain present.

Verification
REQ-031 Reset, then capture DR and 32 shifts with tdi_i=0 -> tdo_o yields 0x1000_5A5B LSB first; instr_o=5'h01 throughout.
REQ-032 Capture IR, then shift 5'h1F in (5 cycles), then update IR -> tdo_o yields 1,0,0,0,0; instr_o=5'h1F; next DR capture plus shift of 1,0,1 -> tdo_o 0,1,0 (one-bit delay).
REQ-033 Load instr 5'h10, user_rdata_i=0xCAFE_F00D, capture and shift in 0x1234_5678, update -> tdo_o yields 0xCAFE_F00D; user_wdata_o=0x1234_5678; user_wvalid_o high for exactly 1 cycle.
REQ-034 Load instr 5'h07 (undefined), then capture DR -> DR length 1 (bypass), user_wvalid_o stays 0 on update.
REQ-035 Assert trst_i after 12 of 32 USERDATA shift cycles -> all outputs at REQ-027 values immediately; user_wvalid_o never pulses.
REQ-036 Build without TAP_USERDATA_EN; rerun REQ-033 stimulus -> one-bit bypass behaviour; user_wdata_o=0; user_wvalid_o=0.

Source files
------------

// File: rtl/tap_regs.sv
// tap_regs: JTAG instruction register plus IDCODE, USERDATA and BYPASS
// data registers, driven by decoded TAP controller state inputs.
// Optional feature macro: TAP_USERDATA_EN enables the USERDATA register
// and the user_* parallel ports. Without it, 5'h10 decodes as BYPASS and
// the user outputs are tied low.
module tap_regs #(
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_5A5B,
   parameter logic [4:0]  IR_RESET     = 5'h01
) (
   input  logic        tck_i,
   input  logic        trst_i,
   input  logic        tdi_i,
   input  logic        shiftIR_i,
   input  logic        captureIR_i,
   input  logic        updateIR_i,
   input  logic        shiftDR_i,
   input  logic        captureDR_i,
   input  logic        updateDR_i,
   input  logic        SelectIR_i,
   output logic        tdo_o,
   output logic [4:0]  instr_o,
   input  logic [31:0] user_rdata_i,
   output logic [31:0] user_wdata_o,
   output logic        user_wvalid_o
);

   typedef enum logic [1:0] {
      SEL_BYPASS = 2'd0,
      SEL_IDCODE = 2'd1,
      SEL_USER   = 2'd2
   } dr_sel_t;

   function automatic dr_sel_t decode(input logic [4:0] ir);
      case (ir)
         5'h01:   decode = SEL_IDCODE;
`ifdef TAP_USERDATA_EN
         5'h10:   decode = SEL_USER;
`endif
         default: decode = SEL_BYPASS;
      endcase
   endfunction

   logic [4:0]  ir_sr;
   logic [31:0] idcode_sr;
   logic        bypass_sr;
   logic        dr_bit0;
   // DR selection is frozen at capture so an IR update mid-scan cannot
   // redirect a shift that is already under way.
   dr_sel_t     dr_sel;

   // Instruction shift register and the active instruction.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         ir_sr   <= 5'b00001;
         instr_o <= IR_RESET;
      end else begin
         if (captureIR_i)
            ir_sr <= 5'b00001;
         else if (shiftIR_i)
            ir_sr <= {tdi_i, ir_sr[4:1]};
         if (updateIR_i)
            instr_o <= ir_sr;
      end
   end

   // Latch the DR selection from the instruction at capture time.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i)
         dr_sel <= decode(IR_RESET);
      else if (captureDR_i)
         dr_sel <= decode(instr_o);
   end

   // IDCODE data register; capture wins over a simultaneous shift.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i)
         idcode_sr <= IDCODE_VALUE;
      else if (captureDR_i) begin
         if (decode(instr_o) == SEL_IDCODE)
            idcode_sr <= IDCODE_VALUE;
      end else if (shiftDR_i && dr_sel == SEL_IDCODE)
         idcode_sr <= {tdi_i, idcode_sr[31:1]};
   end

   // One-bit bypass register.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i)
         bypass_sr <= 1'b0;
      else if (captureDR_i) begin
         if (decode(instr_o) == SEL_BYPASS)
            bypass_sr <= 1'b0;
      end else if (shiftDR_i && dr_sel == SEL_BYPASS)
         bypass_sr <= tdi_i;
   end

`ifdef TAP_USERDATA_EN
   logic [31:0] user_sr;

   // USERDATA shift register loaded from the parallel read port.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i)
         user_sr <= '0;
      else if (captureDR_i) begin
         if (decode(instr_o) == SEL_USER)
            user_sr <= user_rdata_i;
      end else if (shiftDR_i && dr_sel == SEL_USER)
         user_sr <= {tdi_i, user_sr[31:1]};
   end

   // Parallel write port with a single-cycle valid strobe on update.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         user_wdata_o  <= '0;
         user_wvalid_o <= 1'b0;
      end else begin
         user_wvalid_o <= updateDR_i && (dr_sel == SEL_USER);
         if (updateDR_i && dr_sel == SEL_USER)
            user_wdata_o <= user_sr;
      end
   end
`else
   logic unused_rdata;
   assign unused_rdata  = ^user_rdata_i;
   assign user_wdata_o  = '0;
   assign user_wvalid_o = 1'b0;
`endif

   // Serial output bit of the latched data register.
   always_comb begin
      dr_bit0 = bypass_sr;
      case (dr_sel)
         SEL_IDCODE: dr_bit0 = idcode_sr[0];
`ifdef TAP_USERDATA_EN
         SEL_USER:   dr_bit0 = user_sr[0];
`endif
         default:    dr_bit0 = bypass_sr;
      endcase
   end

   // TDO changes on the falling edge so the far end samples it on the rise.
   always_ff @(negedge tck_i or posedge trst_i) begin
      if (trst_i)
         tdo_o <= 1'b0;
      else if (shiftIR_i && SelectIR_i)
         tdo_o <= ir_sr[0];
      else if (shiftDR_i)
         tdo_o <= dr_bit0;
      else
         tdo_o <= 1'b0;
   end

endmodule
